// File: rtl/serial_subtractor_8bits.sv
// Bit-serial A - B - Bin: one difference bit per clock, LSB first, over WIDTH cycles.
// Define SUBTRACTOR_OVF_EN to add the registered signed-overflow output OVF.
//
// state | meaning
// IDLE  | waiting for start, last result held on D/Bout
// SHIFT | producing one difference bit per edge
// DONE  | result just completed, done high for this cycle
module serial_subtractor_8bits #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             Bin,
  output logic [WIDTH-1:0] D,
  output logic             Bout,
  output logic             busy,
  output logic             done
`ifdef SUBTRACTOR_OVF_EN
  ,
  output logic             OVF
`endif
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  state_t state, state_nxt;

  logic [WIDTH-1:0] a_q, b_q, p_q;
  logic             borrow_q;
  logic [CW-1:0]    cnt;
  logic             accept, last;
  logic             diff_bit, borrow_nxt;
  logic [WIDTH-1:0] d_new;

`ifdef SUBTRACTOR_OVF_EN
  logic a_msb, b_msb;
`endif

  assign accept = start && (state != SHIFT);
  assign last   = (cnt == CW'(WIDTH - 1));

  // One-bit full subtractor on the current LSBs of the shifting operands.
  assign diff_bit   = a_q[0] ^ b_q[0] ^ borrow_q;
  assign borrow_nxt = (~a_q[0] & b_q[0]) | (~(a_q[0] ^ b_q[0]) & borrow_q);
  assign d_new      = {diff_bit, p_q[WIDTH-1:1]};

  assign busy = (state == SHIFT);
  assign done = (state == DONE);

  always_ff @(posedge clk) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start) state_nxt = SHIFT;
      SHIFT:   if (last)  state_nxt = DONE;
      DONE:    state_nxt = start ? SHIFT : IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      a_q      <= '0;
      b_q      <= '0;
      p_q      <= '0;
      borrow_q <= 1'b0;
      cnt      <= '0;
      D        <= '0;
      Bout     <= 1'b0;
`ifdef SUBTRACTOR_OVF_EN
      a_msb    <= 1'b0;
      b_msb    <= 1'b0;
      OVF      <= 1'b0;
`endif
    end else if (accept) begin
      a_q      <= A;
      b_q      <= B;
      borrow_q <= Bin;
      cnt      <= '0;
`ifdef SUBTRACTOR_OVF_EN
      a_msb    <= A[WIDTH-1];
      b_msb    <= B[WIDTH-1];
`endif
    end else if (state == SHIFT) begin
      a_q      <= a_q >> 1;
      b_q      <= b_q >> 1;
      borrow_q <= borrow_nxt;
      p_q      <= d_new;
      cnt      <= cnt + CW'(1);
      // Outputs only move on the final bit so partial results never appear.
      if (last) begin
        D    <= d_new;
        Bout <= borrow_nxt;
`ifdef SUBTRACTOR_OVF_EN
        OVF  <= (a_msb ^ b_msb) & (a_msb ^ diff_bit);
`endif
      end
    end
  end

endmodule
